riscboy_ppu_busmaster: RTL

Shares the PPU's single AHB-Lite master port between `N_REQ` pixel-fetch requesters: background layers, sprite fetch and palette/tilemap loaders. Each requester uses the PPU-internal handshake (`vld`/`addr`/`size` → `rdy`/`data`). The block round-robin arbitrates those requests and issues them as pipelined single reads on AHB-Lite. It returns lane-replicated read data to whichever requester owns the completing data phase. It sits between the PPU layer engines and the system bus fabric.

---
 rtl/riscboy_ppu_bus_pkg.sv | 35 +++
 rtl/riscboy_ppu_rr_sel.sv | 35 +++
 rtl/riscboy_ppu_busmaster.sv | 124 ++++++++++++
 3 files changed

// File: rtl/riscboy_ppu_bus_pkg.sv
// Shared definitions for the PPU bus master: AHB-Lite transfer types, the
// PPU-internal size encoding, and the read-data lane replication helper.
package riscboy_ppu_bus_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Pick the addressed byte/halfword out of a bus word and replicate it
    // across all lanes, so requesters never need to shift read data.
    function automatic logic [31:0] lane_replicate(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: return {4{b}};
            SIZE_HALF: return {2{h}};
            default:   return word;
        endcase
    endfunction

endpackage

// File: rtl/riscboy_ppu_rr_sel.sv
// Rotating-priority one-hot selector.
// Ports:
//   req - request vector, one bit per requester
//   ptr - index of the highest-priority requester; search wraps from here
//   gnt - one-hot grant (all zero when nothing requested)
//   idx - binary index of the granted requester
//   any - at least one request present
module riscboy_ppu_rr_sel #(
    parameter int N_REQ = 2,
    localparam int W_IDX = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [W_IDX-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [W_IDX-1:0] idx,
    output logic             any
);

    always_comb begin : sel
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = W_IDX'(j);
            end
        end
    end

endmodule

// File: rtl/riscboy_ppu_busmaster.sv
// Shares the PPU's single AHB-Lite master port between N_REQ pixel-fetch
// requesters. Requests are round-robin arbitrated and issued as pipelined
// single reads; lane-replicated read data is returned to the data-phase owner.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   req_vld/addr/size     - packed per-requester request handshake
//   req_rdy, req_data     - one-cycle completion pulse and shared read data
//   ahbl_*                - AHB-Lite master (read-only, single transfers)
module riscboy_ppu_busmaster
    import riscboy_ppu_bus_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_vld,
    input  logic [N_REQ*W_ADDR-1:0] req_addr,
    input  logic [N_REQ*2-1:0]      req_size,
    output logic [N_REQ-1:0]        req_rdy,
    output logic [W_DATA-1:0]       req_data,
    output logic [1:0]              ahbl_htrans,
    output logic [W_ADDR-1:0]       ahbl_haddr,
    output logic [2:0]              ahbl_hsize,
    output logic                    ahbl_hwrite,
    input  logic                    ahbl_hready,
    input  logic                    ahbl_hresp,
    input  logic [W_DATA-1:0]       ahbl_hrdata
);

    localparam int W_IDX = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic             dph_vld;
    logic [W_IDX-1:0] dph_owner;
    logic [1:0]       dph_size;
    logic [1:0]       dph_lane;
    logic [W_IDX-1:0] rr_ptr;

    logic [N_REQ-1:0]  owner_mask;
    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  win_gnt;
    logic [W_IDX-1:0]  win_idx;
    logic              win_any;
    logic [W_ADDR-1:0] win_addr;
    logic [1:0]        win_size;
    logic [W_IDX-1:0]  ptr_next;
    logic              err_first;
    logic              issue;
    logic              accept;
    logic              dph_done;

    // Address phase
    always_comb begin
        owner_mask = '0;
        for (int i = 0; i < N_REQ; i++)
            owner_mask[i] = dph_vld && (dph_owner == W_IDX'(i));
    end

    // The data-phase owner is still waiting on its rdy, so it must not be
    // granted again in the same cycle even if it keeps vld high.
    assign eligible = req_vld & ~owner_mask;

    riscboy_ppu_rr_sel #(
        .N_REQ (N_REQ)
    ) u_rr_sel (
        .req (eligible),
        .ptr (rr_ptr),
        .gnt (win_gnt),
        .idx (win_idx),
        .any (win_any)
    );

    always_comb begin
        win_addr = '0;
        win_size = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_gnt[i]) begin
                win_addr = req_addr[i*W_ADDR +: W_ADDR];
                win_size = req_size[2*i +: 2];
            end
        end
    end

    // First cycle of a two-cycle error response: AHB requires the next
    // transfer to be cancelled, so drop to IDLE.
    assign err_first = ahbl_hresp && !ahbl_hready;
    assign issue     = win_any && !err_first && !rst;
    assign accept    = issue && ahbl_hready;
    assign ptr_next  = (win_idx == W_IDX'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

    assign ahbl_htrans = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahbl_haddr  = issue ? win_addr : '0;
    assign ahbl_hsize  = issue ? {1'b0, win_size} : 3'b000;
    assign ahbl_hwrite = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dph_vld   <= 1'b0;
            dph_owner <= '0;
            rr_ptr    <= '0;
        end else if (ahbl_hready) begin
            dph_vld <= accept;
            if (accept) begin
                dph_owner <= win_idx;
                rr_ptr    <= ptr_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            dph_size <= win_size;
            dph_lane <= win_addr[1:0];
        end
    end

    // Data phase
    assign dph_done = dph_vld && ahbl_hready && !rst;
    assign req_rdy  = dph_done ? owner_mask : '0;
    assign req_data = (dph_done && !ahbl_hresp) ?
                      lane_replicate(ahbl_hrdata, dph_size, dph_lane) : '0;

endmodule
